// File: rtl/psram_wb_rdcache.sv
// Direct-mapped write-through read cache placed between the
// core-side Wishbone master and the PSRAM controller slave.
module psram_wb_rdcache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [31:0] s_adr_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        flush_i
);

  localparam int IW = $clog2(LINES);
  localparam int LW = $clog2(LINE_WORDS);
  localparam int TW = ADDR_W - IW - LW - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_t;

  state_t state, state_n;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [31:0]      mem  [LINES*LINE_WORDS];

  logic [ADDR_W-1:2] r_adr;
  logic [3:0]        r_sel;
  logic [31:0]       r_dat;
  logic [LW-1:0]     fill_cnt;
  logic              flush_pend;

  logic          req;
  logic [IW-1:0] s_idx, r_idx;
  logic [TW-1:0] s_tag, r_tag;
  logic [LW-1:0] s_word, r_word;
  logic          s_hit, r_hit;
  logic          last;
  logic          m_done;
  logic          unused_ok;

  assign req    = s_cyc_i & s_stb_i;
  assign s_idx  = s_adr_i[IW+LW+1:LW+2];
  assign s_tag  = s_adr_i[ADDR_W-1:IW+LW+2];
  assign s_word = s_adr_i[LW+1:2];
  assign s_hit  = valid[s_idx] && (tags[s_idx] == s_tag);

  assign r_idx  = r_adr[IW+LW+1:LW+2];
  assign r_tag  = r_adr[ADDR_W-1:IW+LW+2];
  assign r_word = r_adr[LW+1:2];
  assign r_hit  = valid[r_idx] && (tags[r_idx] == r_tag);

  assign last   = (fill_cnt == LW'(LINE_WORDS - 1));
  assign m_done = m_stb_o & m_ack_i;

  assign m_cyc_o   = m_stb_o;
  assign s_ack_o   = (state == ACK) & req;
  assign unused_ok = &{1'b0, s_adr_i[31:ADDR_W]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (s_we_i)     state_n = WRITE;
          else if (s_hit) state_n = ACK;
          else            state_n = FILL;
        end
      end
      FILL:    if (m_done && last) state_n = ACK;
      WRITE:   if (m_done) state_n = ACK;
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid      <= '0;
      fill_cnt   <= '0;
      flush_pend <= 1'b0;
      r_adr      <= '0;
      r_sel      <= '0;
      r_dat      <= '0;
      s_dat_o    <= '0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= '0;
      m_sel_o    <= '0;
      m_dat_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            r_adr <= s_adr_i[ADDR_W-1:2];
            r_sel <= s_sel_i;
            r_dat <= s_dat_i;
            if (s_we_i) begin
              m_stb_o <= 1'b1;
              m_we_o  <= 1'b1;
              m_adr_o <= 32'(s_adr_i[ADDR_W-1:0]);
              m_sel_o <= s_sel_i;
              m_dat_o <= s_dat_i;
            end else if (s_hit) begin
              s_dat_o <= mem[{s_idx, s_word}];
            end else begin
              fill_cnt   <= '0;
              flush_pend <= 1'b0;
              m_stb_o    <= 1'b1;
              m_we_o     <= 1'b0;
              m_sel_o    <= 4'hF;
              m_adr_o    <= 32'({s_tag, s_idx, {LW{1'b0}}, 2'b00});
            end
          end
        end
        FILL: begin
          if (m_stb_o) begin
            if (m_ack_i) begin
              m_stb_o  <= 1'b0;
              fill_cnt <= fill_cnt + LW'(1);
              if (fill_cnt == r_word) s_dat_o <= m_dat_i;
              if (last && !flush_pend) valid[r_idx] <= 1'b1;
            end
          end else begin
            // strobe re-armed only after an idle cycle
            m_stb_o <= 1'b1;
            m_adr_o <= 32'({r_tag, r_idx, fill_cnt, 2'b00});
          end
        end
        WRITE: begin
          if (m_done) begin
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (flush_i) begin
        valid      <= '0;
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == FILL && m_done) begin
      mem[{r_idx, fill_cnt}] <= m_dat_i;
      if (last) tags[r_idx] <= r_tag;
    end
    if (state == WRITE && m_done && r_hit) begin
      for (int b = 0; b < 4; b++)
        if (r_sel[b]) mem[{r_idx, r_word}][8*b +: 8] <= r_dat[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_psram_wb_rdcache.sv
// Randomised scoreboard bench for psram_wb_rdcache with a
// behavioural PSRAM slave and a line-level cache reference.
module tb_psram_wb_rdcache;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [31:0] s_adr_i, s_dat_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        flush_i;

  psram_wb_rdcache dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
    .s_adr_i(s_adr_i), .s_sel_i(s_sel_i), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_adr_o(m_adr_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } ds_t;

  typedef struct {
    bit          we;
    logic [31:0] dat;
  } sb_t;

  ds_t ds_q[$];
  sb_t sb_q[$];
  logic [31:0] psram   [int];
  logic [31:0] ref_mem [int];
  bit  ref_valid [16];
  int  ref_tag   [16];
  int  ds_done = 0;
  int  checks  = 0;
  int  errors  = 0;

  function automatic logic [31:0] init_word(int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ps_rd(int w);
    if (psram.exists(w)) return psram[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] sel);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"},
        {24'h0, s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, 32'h0);
    chk({name, "_madr"}, m_adr_o, 32'h0);
    chk({name, "_mdat"}, m_dat_o, 32'h0);
    chk({name, "_sdat"}, s_dat_o, 32'h0);
  endtask

  // reference model: a read misses unless the line holds the same tag
  task automatic model_read(input logic [31:0] a, input bit alloc,
                            output bit hit);
    int line;
    int tag;
    ds_t d;
    line = int'(a[7:4]);
    tag  = int'(a[23:8]);
    hit  = ref_valid[line] && ref_tag[line] == tag;
    if (!hit) begin
      for (int i = 0; i < 4; i++) begin
        d.we  = 1'b0;
        d.adr = {8'h0, a[23:4], 4'h0} + 32'(4 * i);
        d.sel = 4'hF;
        d.dat = 32'h0;
        ds_q.push_back(d);
      end
      if (alloc) begin
        ref_valid[line] = 1'b1;
        ref_tag[line]   = tag;
      end
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic wb_req(input bit we, input logic [31:0] a,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output int lat);
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we;
    s_adr_i = a; s_sel_i = sel; s_dat_i = dat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_ack_o && lat < 200);
    chk("ack_seen", 32'(s_ack_o), 32'h1);
    #1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input bit alloc);
    bit  hit;
    int  lat;
    sb_t e;
    model_read(a, alloc, hit);
    e.we  = 1'b0;
    e.dat = ref_rd(int'(a[23:2]));
    sb_q.push_back(e);
    wb_req(1'b0, a, 4'($urandom), 32'($urandom), lat);
    if (hit) chk("hit_latency", 32'(lat), 32'h1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] sel,
                          input logic [31:0] dat);
    int  lat;
    int  w;
    ds_t d;
    sb_t e;
    w = int'(a[23:2]);
    d.we = 1'b1; d.adr = {8'h0, a[23:0]}; d.sel = sel; d.dat = dat;
    ds_q.push_back(d);
    ref_mem[w] = merge(ref_rd(w), dat, sel);
    e.we = 1'b1; e.dat = 32'h0;
    sb_q.push_back(e);
    wb_req(1'b1, a, sel, dat, lat);
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    model_flush();
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (ds_done < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ds_progress", 32'(ds_done >= target), 32'h1);
  endtask

  function automatic logic [31:0] rnd_adr();
    return {8'($urandom), 14'h0, 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
  endfunction

  // PSRAM controller model: random wait, 1-cycle ack pulse
  initial begin
    int  pend;
    ds_t d;
    int  w;
    pend = -1;
    m_ack_i = 1'b0;
    m_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        m_ack_i = 1'b0;
        pend = -1;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
        chk("stb_drop_after_ack", 32'(m_stb_o), 32'h0);
      end else if (m_stb_o) begin
        if (pend < 0) begin
          chk("cyc_eq_stb", 32'(m_cyc_o), 32'h1);
          if (ds_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ds_access adr=%h we=%0b", m_adr_o, m_we_o);
          end else begin
            d = ds_q.pop_front();
            chk("ds_we", 32'(m_we_o), 32'(d.we));
            chk("ds_adr", m_adr_o, d.adr);
            chk("ds_sel", 32'(m_sel_o), 32'(d.sel));
            if (d.we) chk("ds_dat", m_dat_o, d.dat);
          end
          pend = $urandom_range(0, 2);
        end
        if (pend == 0) begin
          w = int'(m_adr_o[23:2]);
          if (m_we_o) psram[w] = merge(ps_rd(w), m_dat_o, m_sel_o);
          else        m_dat_i = ps_rd(w);
          m_ack_i = 1'b1;
          ds_done++;
          pend = -1;
        end else begin
          pend--;
        end
      end
    end
  end

  sb_t mon_e;
  always @(negedge clk) begin
    if (!rst_i && s_ack_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack dat=%h", s_dat_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (!mon_e.we) chk("read_data", s_dat_o, mon_e.dat);
        chk("ds_all_issued", 32'(ds_q.size()), 32'h0);
      end
    end
  end

  initial begin
    bit hit;
    int base;
    rst_i = 1'b1; flush_i = 1'b0;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    s_adr_i = '0; s_sel_i = '0; s_dat_i = '0;
    model_flush();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_i = 1'b0;

    do_read(32'h0000_0014, 1'b1);
    do_read(32'h0000_0018, 1'b1);
    do_write(32'h0000_0014, 4'b0010, 32'h0000_AB00);
    do_read(32'h0000_0014, 1'b1);
    do_read(32'h0000_0010, 1'b1);
    do_read(32'h0000_0110, 1'b1);
    do_read(32'h0000_0010, 1'b1);

    pulse_flush();
    do_read(32'h0000_0018, 1'b1);
    do_read(32'h0000_001C, 1'b1);

    // flush while the line is being filled: data returned, line stays invalid
    base = ds_done;
    fork
      do_read(32'h0000_0224, 1'b0);
      begin
        wait_done(base + 1);
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        model_flush();
      end
    join
    do_read(32'h0000_0224, 1'b1);

    // master abandons a miss: fill completes silently and still allocates
    pulse_flush();
    model_read(32'h0000_0330, 1'b1, hit);
    base = ds_done;
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
    s_adr_i = 32'h0000_0330; s_sel_i = 4'hF;
    wait_done(base + 1);
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    wait_done(base + 4);
    repeat (3) @(negedge clk);
    chk("drop_ds_queue", 32'(ds_q.size()), 32'h0);
    do_read(32'h0000_0334, 1'b1);

    // reset after the second word of a refill
    pulse_flush();
    model_read(32'h0000_0140, 1'b1, hit);
    base = ds_done;
    @(negedge clk);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
    s_adr_i = 32'h0000_0148; s_sel_i = 4'hF;
    wait_done(base + 2);
    rst_i = 1'b1;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    @(negedge clk);
    check_zero("rst_mid_fill");
    rst_i = 1'b0;
    ds_q.delete();
    model_flush();
    do_read(32'h0000_0148, 1'b1);
    do_read(32'h0000_0140, 1'b1);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 68)      do_read(rnd_adr(), 1'b1);
      else if (r < 95) do_write(rnd_adr(), 4'($urandom_range(1, 15)), $urandom);
      else             pulse_flush();
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
